// File: rtl/pixel_sink_pkg.sv
// Shared display definitions for the drawer-to-framebuffer path: screen geometry,
// colour constants and the pixel_sink FSM state encoding.
package pixel_sink_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int COORD_W  = 8;

    localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
    localparam logic [COLOUR_W-1:0] BLUE    = 3'b001;
    localparam logic [COLOUR_W-1:0] GREEN   = 3'b010;
    localparam logic [COLOUR_W-1:0] CYAN    = 3'b011;
    localparam logic [COLOUR_W-1:0] RED     = 3'b100;
    localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
    localparam logic [COLOUR_W-1:0] YELLOW  = 3'b110;
    localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pixel_sink_if.sv
// Drawer write port, readback port and status of the pixel sink, bundled so drawers,
// game logic and the sink share one set of names.
interface pixel_sink_if;
    import pixel_sink_pkg::*;

    // No handshake: plot and rd_req are single-cycle strobes that are always accepted;
    // rd_valid pulses once per rd_req, two cycles later, in request order.
    logic                plot;
    logic [COORD_W-1:0]  in_x;
    logic [COORD_W-1:0]  in_y;
    logic [COLOUR_W-1:0] in_colour;
    logic                clear_req;
    logic                rd_req;
    logic [COORD_W-1:0]  rd_x;
    logic [COORD_W-1:0]  rd_y;
    logic                rd_valid;
    logic [COLOUR_W-1:0] rd_colour;
    logic                busy;
    logic [7:0]          drop_count;

    modport master (
        output plot, in_x, in_y, in_colour, clear_req, rd_req, rd_x, rd_y,
        input  rd_valid, rd_colour, busy, drop_count
    );

    modport slave (
        input  plot, in_x, in_y, in_colour, clear_req, rd_req, rd_x, rd_y,
        output rd_valid, rd_colour, busy, drop_count
    );

endinterface

// File: rtl/pixel_sink_fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one read port with a registered
// output. A read of the address being written returns the previous contents.
module pixel_sink_fb_ram
    import pixel_sink_pkg::*;
#(
    parameter int DEPTH = SCREEN_W * SCREEN_H,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic                clock,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [COLOUR_W-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [COLOUR_W-1:0] rd_data
);

    logic [COLOUR_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pixel_sink.sv
// Framebuffer sink for drawer pixel writes: clear sweep FSM, write mux, drop counter
// and a two-cycle colour readback pipeline for game logic.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int                  WIDTH     = SCREEN_W,
    parameter int                  HEIGHT    = SCREEN_H,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = BLACK
) (
    input  logic         clock,
    input  logic         resetn,
    pixel_sink_if.slave  bus,
    output state_e       state_dbg
);

    localparam int            DEPTH     = WIDTH * HEIGHT;
    localparam int            AW        = addr_width(DEPTH);
    localparam int            PW        = 2 * COORD_W + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return (int'(x) < WIDTH) && (int'(y) < HEIGHT);
    endfunction

    function automatic logic [AW-1:0] lin_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return AW'(PW'(y) * PW'(WIDTH) + PW'(x));
    endfunction

    state_e              state, state_next;
    logic [AW-1:0]       clr_addr, clr_next;
    logic                wr_ok, wr_en;
    logic [AW-1:0]       wr_addr;
    logic [COLOUR_W-1:0] wr_data;
    logic [7:0]          drop_count;
    logic                rd_ok, rd_v1, rd_ok1, rd_valid;
    logic [AW-1:0]       rd_addr;
    logic [COLOUR_W-1:0] ram_q, rd_colour;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_next;
        end
    end

    always_comb begin
        state_next = state;
        clr_next   = clr_addr;
        case (state)
            ST_CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    state_next = ST_IDLE;
                    clr_next   = '0;
                end else begin
                    clr_next = clr_addr + AW'(1);
                end
            end
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_next = ST_CLEAR;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // The sweep owns the write port while clearing; plots are only taken in IDLE.
    always_comb begin
        wr_ok   = in_range(bus.in_x, bus.in_y);
        wr_en   = 1'b0;
        wr_addr = lin_addr(bus.in_x, bus.in_y);
        wr_data = bus.in_colour;
        if (state == ST_CLEAR) begin
            wr_en   = resetn;
            wr_addr = clr_addr;
            wr_data = BG_COLOUR;
        end else if (bus.plot && wr_ok) begin
            wr_en = resetn;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            drop_count <= '0;
        end else if (bus.plot && (state == ST_CLEAR || !wr_ok) && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // Out-of-range reads still occupy a slot; their RAM address is parked at 0.
    always_comb begin
        rd_ok   = in_range(bus.rd_x, bus.rd_y);
        rd_addr = rd_ok ? lin_addr(bus.rd_x, bus.rd_y) : '0;
    end

    // The RAM samples the request address directly so a same-cycle write is not yet
    // visible; the second stage substitutes BG_COLOUR for out-of-range requests.
    pixel_sink_fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_v1     <= 1'b0;
            rd_ok1    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_colour <= '0;
        end else begin
            rd_v1    <= bus.rd_req;
            rd_ok1   <= rd_ok;
            rd_valid <= rd_v1;
            if (rd_v1) begin
                rd_colour <= rd_ok1 ? ram_q : BG_COLOUR;
            end
        end
    end

    assign bus.rd_valid   = rd_valid;
    assign bus.rd_colour  = rd_colour;
    assign bus.busy       = (state == ST_CLEAR);
    assign bus.drop_count = drop_count;
    assign state_dbg      = state;

endmodule

// File: tb/tb_pixel_sink.sv
// Bench for pixel_sink on a 4x3 framebuffer: directed corner sequences, a vector
// table of write/readback pairs, and random traffic against a behavioural model.
module tb_pixel_sink;
    import pixel_sink_pkg::*;

    localparam int          W     = 4;
    localparam int          H     = 3;
    localparam int          DEPTH = W * H;
    localparam logic [2:0]  BG    = 3'b000;

    logic   clock = 1'b0;
    logic   resetn = 1'b0;
    state_e state_dbg;

    pixel_sink_if bus();

    pixel_sink #(.WIDTH(W), .HEIGHT(H), .BG_COLOUR(BG)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    // Reference model: colour per pixel, remaining sweep cycles, drop total, and the
    // expected readback stream with the cycle each result is due.
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [2:0] ref_mem [DEPTH];
    int         sweep_left = DEPTH;
    int         m_drop     = 0;
    logic [2:0] exp_q [$];
    int         due_q [$];

    typedef struct {
        int         x;
        int         y;
        logic [2:0] c;
        bit         accept;
        logic [2:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit in_rng(input int x, input int y);
        return (x < W) && (y < H);
    endfunction

    task automatic tick();
        int rx, ry, px, py;
        rx = int'(bus.rd_x);
        ry = int'(bus.rd_y);
        px = int'(bus.in_x);
        py = int'(bus.in_y);
        if (!resetn) begin
            sweep_left = DEPTH;
            m_drop     = 0;
            exp_q.delete();
            due_q.delete();
        end else begin
            if (bus.rd_req) begin
                due_q.push_back(cyc + 2);
                exp_q.push_back(in_rng(rx, ry) ? ref_mem[ry * W + rx] : BG);
            end
            if (sweep_left > 0) begin
                if (bus.plot) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                ref_mem[DEPTH - sweep_left] = BG;
                sweep_left--;
            end else begin
                if (bus.plot) begin
                    if (in_rng(px, py)) ref_mem[py * W + px] = bus.in_colour;
                    else m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                end
                if (bus.clear_req) sweep_left = DEPTH;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        check("busy", int'(bus.busy), int'(sweep_left > 0));
        check("drop_count", int'(bus.drop_count), m_drop);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            check("rd_valid", int'(bus.rd_valid), 1);
            check("rd_colour", int'(bus.rd_colour), int'(exp_q[0]));
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
        end else begin
            check("rd_valid_idle", int'(bus.rd_valid), 0);
        end
    endtask

    task automatic drive(input bit p, input int x, input int y, input int c,
                         input bit clr, input bit rr, input int rx, input int ry);
        bus.plot      = p;
        bus.in_x      = 8'(x);
        bus.in_y      = 8'(y);
        bus.in_colour = 3'(c);
        bus.clear_req = clr;
        bus.rd_req    = rr;
        bus.rd_x      = 8'(rx);
        bus.rd_y      = 8'(ry);
    endtask

    task automatic idle_tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic read_check(input string name, input int x, input int y, input int exp);
        drive(0, 0, 0, 0, 0, 1, x, y);
        tick();
        check({name, "_early"}, int'(bus.rd_valid), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check({name, "_valid"}, int'(bus.rd_valid), 1);
        check(name, int'(bus.rd_colour), exp);
    endtask

    task automatic count_busy(output int n, input int pulse_at);
        n = bus.busy ? 1 : 0;
        for (int i = 0; i < 60; i++) begin
            drive(0, 0, 0, 0, (i == pulse_at), 0, 0, 0);
            tick();
            if (bus.busy) n++;
            else break;
        end
        bus.clear_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && bus.busy; i++) idle_tick();
        if (bus.busy) check("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0;
        vecs[0] = '{0,   0,   3'b001, 1, 3'b001};
        vecs[1] = '{3,   2,   3'b110, 1, 3'b110};
        vecs[2] = '{3,   0,   3'b010, 1, 3'b010};
        vecs[3] = '{0,   2,   3'b100, 1, 3'b100};
        vecs[4] = '{4,   1,   3'b111, 0, 3'b000};
        vecs[5] = '{0,   0,   3'b011, 1, 3'b011};
        vecs[6] = '{2,   3,   3'b101, 0, 3'b000};
        vecs[7] = '{255, 255, 3'b111, 0, 3'b000};
        vecs[8] = '{2,   1,   3'b000, 1, 3'b000};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = BG;

        // Reset and the power-up sweep.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        repeat (3) tick();
        check("rst_rd_colour", int'(bus.rd_colour), 0);
        check("rst_state", int'(state_dbg), int'(ST_CLEAR));
        resetn = 1'b1;
        count_busy(n, -1);
        check("init_sweep_len", n, 12);
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 0, 0, 0, 1, a % W, a / W);
            tick();
        end
        idle_tick();
        idle_tick();

        // Plot then read back with two-cycle latency.
        drive(1, 2, 1, 3'b101, 0, 0, 0, 0);
        tick();
        read_check("t2_readback", 2, 1, 3'b101);

        // Write/readback vector table.
        foreach (vecs[i]) begin
            d0 = int'(bus.drop_count);
            drive(1, vecs[i].x, vecs[i].y, vecs[i].c, 0, 0, 0, 0);
            tick();
            check("vec_drop_delta", int'(bus.drop_count) - d0, vecs[i].accept ? 0 : 1);
            read_check("vec_readback", vecs[i].x, vecs[i].y, vecs[i].exp_rd);
        end

        // Same-cycle write and read of one pixel sees the old colour.
        drive(1, 1, 1, 3'b011, 0, 1, 1, 1);
        tick();
        idle_tick();
        check("t4_old_valid", int'(bus.rd_valid), 1);
        check("t4_old_colour", int'(bus.rd_colour), 3'b000);
        read_check("t4_repeat", 1, 1, 3'b011);

        // Rejected writes: two out of range, one during a sweep, then saturation.
        d0 = int'(bus.drop_count);
        drive(1, 4, 0, 3'b111, 0, 0, 0, 0);
        tick();
        drive(1, 0, 3, 3'b111, 0, 0, 0, 0);
        tick();
        read_check("t3_no_alias", 0, 1, 3'b000);
        read_check("t3_kept", 3, 2, 3'b110);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        idle_tick();
        idle_tick();
        drive(1, 1, 0, 3'b111, 0, 0, 0, 0);
        tick();
        wait_idle();
        check("t3_drop_delta", int'(bus.drop_count) - d0, 3);
        read_check("t3_sweep_plot_lost", 1, 0, 3'b000);
        for (int i = 0; i < 300; i++) begin
            drive(1, 200, 0, 3'b111, 0, 0, 0, 0);
            tick();
        end
        check("t3_saturate", int'(bus.drop_count), 255);

        // Fill white, clear, and a second clear_req mid-sweep is ignored.
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                drive(1, x, y, 3'b111, 0, 0, 0, 0);
                tick();
            end
        end
        read_check("t5_filled", 3, 2, 3'b111);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        count_busy(n, 4);
        check("t5_sweep_len", n, 12);
        for (int a = 0; a < DEPTH; a++) read_check("t5_cleared", a % W, a / W, 3'b000);

        // Reset mid-sweep with a read in flight.
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        repeat (5) idle_tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        tick();
        check("t6_no_valid", int'(bus.rd_valid), 0);
        resetn = 1'b1;
        count_busy(n, -1);
        check("t6_sweep_len", n, 12);
        check("t6_drop_zero", int'(bus.drop_count), 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 4),
                  $urandom_range(0, 7), ($urandom_range(0, 49) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 4));
            tick();
        end
        idle_tick();
        idle_tick();
        check("final_queue_drained", due_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
